// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage payload layouts and their widths.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic        memtoreg;
    logic [4:0]  rd;
    logic [31:0] ddata;
    logic        regwrite;
    logic        floatwb;
  } wb_payload_t;

  localparam int unsigned WB_PAYLOAD_W = $bits(wb_payload_t);

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_STALL_CNT_EN to build the backpressure stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = WB_PAYLOAD_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_fire, out_fire, m_free;

  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid_q & out_ready;
  assign m_free    = ~m_valid_q | out_fire;

  // Data registers only load alongside their valid; a cleared valid leaves data as-is.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = in_fire;
        if (in_fire) s_data_d = in_data;
      end else begin
        m_valid_d = in_fire;
        if (in_fire) m_data_d = in_data;
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(m_valid_q & ~out_ready),
    .cnt_o(stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule
